// File: rtl/blinkn_pwm.sv
// N-channel LED/indicator driver: shared prescaler and phase counter feeding
// per-channel OFF/ON/PWM/ONESHOT mode logic, programmed by a one-cycle write port.
module blinkn_pwm #(
  parameter int unsigned NR_CH   = 4,
  parameter int unsigned PRE_DIV = 1000,
  parameter int unsigned DUTY_W  = 8,
  localparam int unsigned CH_W   = (NR_CH > 1) ? $clog2(NR_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              clr_i,
  input  logic [NR_CH-1:0]  en_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [DUTY_W-1:0] cfg_duty_i,
  output logic              tick_o,
  output logic [NR_CH-1:0]  out_o,
  output logic [NR_CH-1:0]  done_o
);

  localparam int unsigned PRE_W = $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  logic [PRE_W-1:0]              pre_q, pre_d;
  logic [DUTY_W-1:0]             phase_q, phase_d;
  logic                          tick_q, tick_d;
  logic [NR_CH-1:0][1:0]         mode_q, mode_d;
  logic [NR_CH-1:0][DUTY_W-1:0]  duty_q, duty_d;
  logic [NR_CH-1:0][DUTY_W-1:0]  cnt_q, cnt_d;
  logic [NR_CH-1:0]              out_q, out_d;
  logic [NR_CH-1:0]              done_q, done_d;
  logic [NR_CH-1:0]              raw;

  always_comb begin
    pre_d   = pre_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (clr_i) begin
      pre_d   = '0;
      phase_d = '0;
    end else begin
      tick_d  = (pre_q == PRE_LAST);
      pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      phase_d = tick_q ? phase_q + 1'b1 : phase_q;
    end
  end

  always_comb begin
    mode_d = mode_q;
    duty_d = duty_q;
    cnt_d  = cnt_q;
    done_d = '0;
    raw    = '0;
    out_d  = '0;
    for (int unsigned c = 0; c < NR_CH; c++) begin
      case (mode_q[c])
        MODE_ON:      raw[c] = 1'b1;
        MODE_PWM:     raw[c] = (phase_q < duty_q[c]);
        MODE_ONESHOT: raw[c] = (cnt_q[c] != '0);
        default:      raw[c] = 1'b0;
      endcase
      out_d[c] = en_i[c] & raw[c];

      // A write to this channel takes precedence over a same-cycle tick decrement;
      // out-of-range channel indices never match any c and are dropped.
      if (cfg_we_i && (32'(cfg_ch_i) == c)) begin
        duty_d[c] = cfg_duty_i;
        if (cfg_mode_i == MODE_ONESHOT) begin
          cnt_d[c] = cfg_duty_i;
          if (cfg_duty_i == '0) begin
            mode_d[c] = MODE_OFF;
            done_d[c] = 1'b1;
          end else begin
            mode_d[c] = MODE_ONESHOT;
          end
        end else begin
          mode_d[c] = cfg_mode_i;
          cnt_d[c]  = '0;
        end
      end else if (tick_q && (mode_q[c] == MODE_ONESHOT) && (cnt_q[c] != '0)) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
        if (cnt_q[c] == DUTY_W'(1)) begin
          mode_d[c] = MODE_OFF;
          done_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      pre_q   <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign tick_o = tick_q;
  assign out_o  = out_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_blinkn_pwm.sv
// Directed bench for blinkn_pwm (NR_CH=2, PRE_DIV=4, DUTY_W=3), plus a 3-channel
// instance to reach an out-of-range channel index.
module tb_blinkn_pwm;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [1:0] en;
  logic       we;
  logic [0:0] ch;
  logic [1:0] mode;
  logic [2:0] duty;
  logic       tick;
  logic [1:0] out;
  logic [1:0] done;

  logic       we3;
  logic [1:0] ch3;
  logic       tick3;
  logic [2:0] out3;
  logic [2:0] done3;

  int checks = 0;
  int errors = 0;

  blinkn_pwm #(.NR_CH(2), .PRE_DIV(4), .DUTY_W(3)) dut (
    .clk_i(clk), .rst_in(rst_n), .clr_i(clr), .en_i(en),
    .cfg_we_i(we), .cfg_ch_i(ch), .cfg_mode_i(mode), .cfg_duty_i(duty),
    .tick_o(tick), .out_o(out), .done_o(done)
  );

  blinkn_pwm #(.NR_CH(3), .PRE_DIV(4), .DUTY_W(3)) dut3 (
    .clk_i(clk), .rst_in(rst_n), .clr_i(clr), .en_i(3'b111),
    .cfg_we_i(we3), .cfg_ch_i(ch3), .cfg_mode_i(mode), .cfg_duty_i(duty),
    .tick_o(tick3), .out_o(out3), .done_o(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 2'b00; we = 1'b0; ch = 1'b0;
    mode = 2'd0; duty = 3'd0; we3 = 1'b0; ch3 = 2'd0;

    // Reset state and tick cadence
    step(3);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_out3", 32'(out3), 32'h0);
    rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step(1);
      chk($sformatf("tick_n%0d", n), 32'(tick), 32'((n == 4) || (n == 8)));
    end
    rst_n = 1'b0;
    #1;
    chk("tick_async_rst", 32'(tick), 32'h0);
    #1;
    rst_n = 1'b1;

    // ON and enable mask
    we = 1'b1; ch = 1'b0; mode = 2'd1; duty = 3'd0; en = 2'b01;
    step(1);
    we = 1'b0;
    chk("on_latency", 32'(out), 32'h0);
    step(1);
    chk("on_out", 32'(out), 32'h1);
    en = 2'b00;
    step(1);
    chk("on_masked", 32'(out), 32'h0);

    // PWM duty 3, 0, 7 on ch1, realigned with clr each time
    en = 2'b10;
    clr = 1'b1; we = 1'b1; ch = 1'b1; mode = 2'd2; duty = 3'd3;
    step(1);
    clr = 1'b0; we = 1'b0;
    step(2);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("pwm3_p%0d", p), 32'(out[1]), 32'(p < 3));
      step(4);
    end
    clr = 1'b1; we = 1'b1; ch = 1'b1; mode = 2'd2; duty = 3'd0;
    step(1);
    clr = 1'b0; we = 1'b0;
    step(2);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("pwm0_p%0d", p), 32'(out[1]), 32'h0);
      step(4);
    end
    clr = 1'b1; we = 1'b1; ch = 1'b1; mode = 2'd2; duty = 3'd7;
    step(1);
    clr = 1'b0; we = 1'b0;
    step(2);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("pwm7_p%0d", p), 32'(out[1]), 32'(p < 7));
      step(4);
    end

    // ONESHOT duty 2 on ch0
    en = 2'b01;
    clr = 1'b1; we = 1'b1; ch = 1'b0; mode = 2'd3; duty = 3'd2;
    step(1);
    clr = 1'b0; we = 1'b0;
    step(1);
    chk("os_out_n1", 32'(out[0]), 32'h1);
    chk("os_done_n1", 32'(done[0]), 32'h0);
    step(7);
    chk("os_out_n8", 32'(out[0]), 32'h1);
    chk("os_done_n8", 32'(done[0]), 32'h0);
    step(1);
    chk("os_out_n9", 32'(out[0]), 32'h1);
    chk("os_done_n9", 32'(done[0]), 32'h1);
    step(1);
    chk("os_out_n10", 32'(out[0]), 32'h0);
    chk("os_done_n10", 32'(done[0]), 32'h0);
    step(4);
    chk("os_out_n14", 32'(out[0]), 32'h0);
    chk("os_done_n14", 32'(done[0]), 32'h0);

    // ONESHOT duty 0: immediate done, no output
    we = 1'b1; ch = 1'b0; mode = 2'd3; duty = 3'd0;
    step(1);
    we = 1'b0;
    chk("os0_done", 32'(done[0]), 32'h1);
    chk("os0_out", 32'(out[0]), 32'h0);
    step(1);
    chk("os0_done_clr", 32'(done[0]), 32'h0);
    chk("os0_out2", 32'(out[0]), 32'h0);

    // Rewrite ch0 ON on the tick edge of a running oneshot
    clr = 1'b1; we = 1'b1; ch = 1'b0; mode = 2'd3; duty = 3'd5;
    step(1);
    clr = 1'b0; we = 1'b0;
    step(4);
    chk("col_tick", 32'(tick), 32'h1);
    we = 1'b1; ch = 1'b0; mode = 2'd1; duty = 3'd0;
    step(1);
    we = 1'b0;
    chk("col_done_n5", 32'(done[0]), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk($sformatf("col_out_%0d", i), 32'(out[0]), 32'h1);
      chk($sformatf("col_done_%0d", i), 32'(done[0]), 32'h0);
    end

    // clr mid-period keeps config and restarts the tick period
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_tick_n0", 32'(tick), 32'h0);
    chk("clr_cfg_kept", 32'(out[0]), 32'h1);
    for (int n = 1; n <= 4; n++) begin
      step(1);
      chk($sformatf("clr_tick_n%0d", n), 32'(tick), 32'(n == 4));
    end

    // Out-of-range channel write is ignored; a valid one lands
    we3 = 1'b1; ch3 = 2'd3; mode = 2'd1; duty = 3'd0;
    step(1);
    we3 = 1'b0;
    step(1);
    chk("bad_ch_out3", 32'(out3), 32'h0);
    we3 = 1'b1; ch3 = 2'd2;
    step(1);
    we3 = 1'b0;
    step(1);
    chk("good_ch_out3", 32'(out3), 32'h4);
    chk("main_untouched", 32'(out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
